// File: rtl/seq_gen.sv
// seq_gen: serial bit-sequence transmitter; takes parallel words over valid/ready and shifts them out MSB-first
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   dataIn     parallel word to transmit (sampled only on an accepting edge)
//   dataValid  dataIn is valid
//   dataReady  word is accepted this cycle if dataValid is high
//   seqOut     registered serial bit, MSB first; IDLE_BIT when not valid
//   seqValid   registered qualifier: seqOut carries a data bit
//   busy       transmitter is not idle
//   wordDone   high while the last bit of a word is on seqOut
module seq_gen #(
   parameter int   DATA_W   = 4,
   parameter int   GAP_CYC  = 0,
   parameter logic IDLE_BIT = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] dataIn,
   input  logic              dataValid,
   output logic              dataReady,
   output logic              seqOut,
   output logic              seqValid,
   output logic              busy,
   output logic              wordDone
);
   localparam int BW = $clog2(DATA_W);
   typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, GAP = 2'd2} state_t;
   state_t            state_q, state_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
   logic [7:0]        gap_cnt_q, gap_cnt_d;
   logic              seq_out_q, seq_out_d;
   logic              seq_valid_q, seq_valid_d;
   logic              accept;
   // ready never depends on dataValid, so the handshake has no combinational loop
   assign dataReady = (state_q == IDLE) ||
                      (state_q == SEND && bit_cnt_q == '0 && GAP_CYC == 0) ||
                      (state_q == GAP && gap_cnt_q == 8'd0);
   assign accept    = dataValid && dataReady;
   assign busy      = state_q != IDLE;
   assign wordDone  = state_q == SEND && bit_cnt_q == '0;
   assign seqOut    = seq_out_q;
   assign seqValid  = seq_valid_q;
   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      bit_cnt_d = bit_cnt_q;
      gap_cnt_d = gap_cnt_q;
      case (state_q)
         IDLE: if (accept) begin
            shift_d   = dataIn;
            bit_cnt_d = BW'(DATA_W - 1);
            state_d   = SEND;
         end
         SEND: begin
            shift_d = shift_q << 1;
            if (bit_cnt_q != '0) bit_cnt_d = bit_cnt_q - 1'b1;
            else if (GAP_CYC != 0) begin
               gap_cnt_d = 8'(GAP_CYC - 1);
               state_d   = GAP;
            end else if (accept) begin
               shift_d   = dataIn;
               bit_cnt_d = BW'(DATA_W - 1);
            end else state_d = IDLE;
         end
         GAP: begin
            if (gap_cnt_q != 8'd0) gap_cnt_d = gap_cnt_q - 8'd1;
            else if (accept) begin
               shift_d   = dataIn;
               bit_cnt_d = BW'(DATA_W - 1);
               state_d   = SEND;
            end else state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // outputs are computed from the next state so the registered bit lines up with the shifter
      seq_valid_d = state_d == SEND;
      seq_out_d   = (state_d == SEND) ? shift_d[DATA_W-1] : IDLE_BIT;
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         shift_q     <= '0;
         bit_cnt_q   <= '0;
         gap_cnt_q   <= 8'd0;
         seq_out_q   <= IDLE_BIT;
         seq_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         shift_q     <= shift_d;
         bit_cnt_q   <= bit_cnt_d;
         gap_cnt_q   <= gap_cnt_d;
         seq_out_q   <= seq_out_d;
         seq_valid_q <= seq_valid_d;
      end
   end
endmodule

// File: tb/tb_seq_gen.sv
// tb_seq_gen: directed bench for seq_gen; u0 has no gap and IDLE_BIT=0, u2 has a 2-cycle gap and IDLE_BIT=1
// Observation vectors are {dataReady, seqOut, seqValid, busy, wordDone}.
module tb_seq_gen;
   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [3:0] in0 = 4'h0, in2 = 4'h0;
   logic       vld0 = 1'b0, vld2 = 1'b0;
   logic       rdy0, so0, sv0, bz0, wd0;
   logic       rdy2, so2, sv2, bz2, wd2;
   logic [4:0] v0, v2;
   logic [7:0] hist;
   int         checks = 0, failures = 0, vcnt, dcnt;
   assign v0 = {rdy0, so0, sv0, bz0, wd0};
   assign v2 = {rdy2, so2, sv2, bz2, wd2};
   always #5 clk = ~clk;
   seq_gen #(.DATA_W(4), .GAP_CYC(0), .IDLE_BIT(1'b0)) u0 (
      .clk(clk), .rst(rst), .dataIn(in0), .dataValid(vld0), .dataReady(rdy0),
      .seqOut(so0), .seqValid(sv0), .busy(bz0), .wordDone(wd0));
   seq_gen #(.DATA_W(4), .GAP_CYC(2), .IDLE_BIT(1'b1)) u2 (
      .clk(clk), .rst(rst), .dataIn(in2), .dataValid(vld2), .dataReady(rdy2),
      .seqOut(so2), .seqValid(sv2), .busy(bz2), .wordDone(wd2));
   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask
   initial begin
      #12;
      chk("rst_u0", 8'(v0), 8'b10000);
      chk("rst_u2", 8'(v2), 8'b11000);
      @(negedge clk);
      rst = 1'b1;
      // single word 1001
      in0 = 4'b1001; vld0 = 1'b1;
      chk("t1_idle", 8'(v0), 8'b10000);
      tick(); vld0 = 1'b0;
      chk("t1_b3", 8'(v0), 8'b01110);
      tick(); chk("t1_b2", 8'(v0), 8'b00110);
      tick(); chk("t1_b1", 8'(v0), 8'b00110);
      tick(); chk("t1_b0", 8'(v0), 8'b11111);
      tick(); chk("t1_end", 8'(v0), 8'b10000);
      // back-to-back 1001 then 0110, valid held
      in0 = 4'b1001; vld0 = 1'b1;
      tick(); in0 = 4'b0110;
      chk("t2_w0b3", 8'(v0), 8'b01110);
      tick(); chk("t2_w0b2", 8'(v0), 8'b00110);
      tick(); chk("t2_w0b1", 8'(v0), 8'b00110);
      tick(); chk("t2_w0b0", 8'(v0), 8'b11111);
      tick(); vld0 = 1'b0;
      chk("t2_w1b3", 8'(v0), 8'b00110);
      tick(); chk("t2_w1b2", 8'(v0), 8'b01110);
      tick(); chk("t2_w1b1", 8'(v0), 8'b01110);
      tick(); chk("t2_w1b0", 8'(v0), 8'b10111);
      tick(); chk("t2_end", 8'(v0), 8'b10000);
      // gap insertion on u2: 1010, 2 idle cycles driving IDLE_BIT=1, then 0011
      in2 = 4'b1010; vld2 = 1'b1;
      chk("t3_idle", 8'(v2), 8'b11000);
      tick(); in2 = 4'b0011;
      chk("t3_w0b3", 8'(v2), 8'b01110);
      tick(); chk("t3_w0b2", 8'(v2), 8'b00110);
      tick(); chk("t3_w0b1", 8'(v2), 8'b01110);
      tick(); chk("t3_w0b0", 8'(v2), 8'b00111);
      tick(); chk("t3_gap1", 8'(v2), 8'b01010);
      tick(); chk("t3_gap2", 8'(v2), 8'b11010);
      tick(); vld2 = 1'b0;
      chk("t3_w1b3", 8'(v2), 8'b00110);
      tick(); chk("t3_w1b2", 8'(v2), 8'b00110);
      tick(); chk("t3_w1b1", 8'(v2), 8'b01110);
      tick(); chk("t3_w1b0", 8'(v2), 8'b01111);
      tick(); chk("t3_gap1b", 8'(v2), 8'b01010);
      tick(); chk("t3_gap2b", 8'(v2), 8'b11010);
      tick(); chk("t3_end", 8'(v2), 8'b11000);
      // backpressure: dataIn changes every busy cycle, only 1010 at the ready edge is sent
      in0 = 4'b1100; vld0 = 1'b1;
      tick(); in0 = 4'b0011;
      chk("t4_b3", 8'(v0), 8'b01110);
      tick(); in0 = 4'b0101;
      chk("t4_b2", 8'(v0), 8'b01110);
      tick(); in0 = 4'b0111;
      chk("t4_b1", 8'(v0), 8'b00110);
      tick(); in0 = 4'b1010;
      chk("t4_b0", 8'(v0), 8'b10111);
      tick(); vld0 = 1'b0; in0 = 4'b1111;
      chk("t4_n3", 8'(v0), 8'b01110);
      tick(); chk("t4_n2", 8'(v0), 8'b00110);
      tick(); chk("t4_n1", 8'(v0), 8'b01110);
      tick(); chk("t4_n0", 8'(v0), 8'b10111);
      tick(); chk("t4_end", 8'(v0), 8'b10000);
      tick(); chk("t4_once", 8'(v0), 8'b10000);
      // reset mid-word
      in0 = 4'b1111; vld0 = 1'b1;
      tick(); vld0 = 1'b0;
      chk("t5_b3", 8'(v0), 8'b01110);
      tick(); chk("t5_b2", 8'(v0), 8'b01110);
      #2 rst = 1'b0;
      #1 chk("t5_async_u0", 8'(v0), 8'b10000);
      chk("t5_async_u2", 8'(v2), 8'b11000);
      tick(); rst = 1'b1;
      chk("t5_held", 8'(v0), 8'b10000);
      in0 = 4'b0001; vld0 = 1'b1;
      tick(); vld0 = 1'b0;
      chk("t5_b3n", 8'(v0), 8'b00110);
      tick(); chk("t5_b2n", 8'(v0), 8'b00110);
      tick(); chk("t5_b1n", 8'(v0), 8'b00110);
      tick(); chk("t5_b0n", 8'(v0), 8'b11111);
      tick(); chk("t5_end", 8'(v0), 8'b10000);
      // loopback stream: 1001 repeated twice, no bubble
      in0 = 4'b1001; vld0 = 1'b1; hist = 8'h00; vcnt = 0; dcnt = 0;
      tick();
      for (int i = 0; i < 8; i++) begin
         hist = {hist[6:0], so0};
         vcnt += int'(sv0);
         dcnt += int'(wd0);
         if (i == 4) vld0 = 1'b0;
         tick();
      end
      chk("t6_bits", hist, 8'b10011001);
      chk("t6_valid", 8'(vcnt), 8'd8);
      chk("t6_done", 8'(dcnt), 8'd2);
      chk("t6_end", 8'(v0), 8'b10000);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
